uart: RTL and testbench

- AXI-Stream-to-UART bridge for 8N1 serial links: TX serializer plus RX deserializer in one block, with a runtime-programmable baud prescaler.
- Uses 8x oversampling. One bit time is prescale*8 clk cycles.
- Sits between on-chip byte streams and the external txd/rxd pins. Also used in pin-level loopback, with txd wired to rxd.

---
 rtl/uart.sv | 264 ++++++++++++++++++++++++++
 tb/tb_uart.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart.sv
// uart: AXI-Stream to 8N1 UART bridge with 8x oversampling.
// One bit time is prescale*8 clk cycles (prescale 0 behaves as 1); prescale
// is sampled whenever a bit timer is reloaded.
//
// Ports:
//   clk, rst                   clock, async active-high reset
//   s_axis_tdata/tvalid/tready byte stream into the transmitter
//   m_axis_tdata/tvalid/tready byte stream out of the receiver
//   rxd, txd                   serial pins, idle high
//   tx_busy, rx_busy           direction is mid-frame
//   rx_overrun_error           unread byte was overwritten
//   rx_frame_error             stop bit sampled low
//   prescale                   baud prescaler
//
// Build option: UART_STICKY_ERR_EN makes both error flags sticky until rst;
// without it they are single-cycle pulses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | TX: ready for a byte, txd high. RX: waiting for rxd low
// START    | TX: driving start bit. RX: waiting half a bit to confirm
// DATA     | data bits, LSB first, one bit time each
// STOP     | TX: driving stop bit. RX: waiting to sample mid-stop

module uart #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   input  logic                  rxd,
   output logic                  txd,
   output logic                  tx_busy,
   output logic                  rx_busy,
   output logic                  rx_overrun_error,
   output logic                  rx_frame_error,
   input  logic [15:0]           prescale
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   logic [15:0] w_presc;
   logic [18:0] w_bit_load;
   logic [18:0] w_half_load;

   assign w_presc     = (prescale == 16'd0) ? 16'd1 : prescale;
   assign w_bit_load  = {w_presc, 3'b000} - 19'd1;
   assign w_half_load = {1'b0, w_presc, 2'b00} - 19'd1;

   // ---------------- transmitter ----------------
   tx_state_t             r_tx_state, w_tx_state_n;
   logic [18:0]           r_tx_timer, w_tx_timer_n;
   logic [DATA_WIDTH-1:0] r_tx_shift, w_tx_shift_n;
   logic [CW-1:0]         r_tx_cnt, w_tx_cnt_n;
   logic                  r_txd, w_txd_n;
   logic                  r_tx_ready, w_tx_ready_n;
   logic                  r_tx_busy, w_tx_busy_n;
   logic                  w_tx_tick;

   assign w_tx_tick = (r_tx_timer == 19'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_state <= TX_IDLE;
         r_tx_timer <= '0;
         r_tx_shift <= '0;
         r_tx_cnt   <= '0;
         r_txd      <= 1'b1;
         r_tx_ready <= 1'b0;
         r_tx_busy  <= 1'b0;
      end else begin
         r_tx_state <= w_tx_state_n;
         r_tx_timer <= w_tx_timer_n;
         r_tx_shift <= w_tx_shift_n;
         r_tx_cnt   <= w_tx_cnt_n;
         r_txd      <= w_txd_n;
         r_tx_ready <= w_tx_ready_n;
         r_tx_busy  <= w_tx_busy_n;
      end
   end

   always_comb begin
      w_tx_state_n = r_tx_state;
      w_tx_timer_n = w_tx_tick ? r_tx_timer : r_tx_timer - 19'd1;
      w_tx_shift_n = r_tx_shift;
      w_tx_cnt_n   = r_tx_cnt;
      w_txd_n      = r_txd;
      w_tx_ready_n = r_tx_ready;
      w_tx_busy_n  = r_tx_busy;
      case (r_tx_state)
         TX_IDLE: begin
            w_tx_ready_n = 1'b1;
            w_tx_busy_n  = 1'b0;
            w_txd_n      = 1'b1;
            if (s_axis_tvalid && r_tx_ready) begin
               w_tx_state_n = TX_START;
               w_tx_ready_n = 1'b0;
               w_tx_busy_n  = 1'b1;
               w_txd_n      = 1'b0;
               w_tx_shift_n = s_axis_tdata;
               w_tx_timer_n = w_bit_load;
            end
         end
         TX_START: begin
            if (w_tx_tick) begin
               w_tx_state_n = TX_DATA;
               w_txd_n      = r_tx_shift[0];
               w_tx_shift_n = {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
               w_tx_cnt_n   = '0;
               w_tx_timer_n = w_bit_load;
            end
         end
         TX_DATA: begin
            if (w_tx_tick) begin
               w_tx_timer_n = w_bit_load;
               if (r_tx_cnt == CW'(DATA_WIDTH - 1)) begin
                  w_tx_state_n = TX_STOP;
                  w_txd_n      = 1'b1;
               end else begin
                  w_txd_n      = r_tx_shift[0];
                  w_tx_shift_n = {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
                  w_tx_cnt_n   = r_tx_cnt + CW'(1);
               end
            end
         end
         TX_STOP: begin
            if (w_tx_tick) begin
               w_tx_state_n = TX_IDLE;
               w_tx_ready_n = 1'b1;
               w_tx_busy_n  = 1'b0;
            end
         end
         default: w_tx_state_n = TX_IDLE;
      endcase
   end

   assign txd           = r_txd;
   assign s_axis_tready = r_tx_ready;
   assign tx_busy       = r_tx_busy;

   // ---------------- receiver ----------------
   rx_state_t             r_rx_state, w_rx_state_n;
   logic [18:0]           r_rx_timer, w_rx_timer_n;
   logic [DATA_WIDTH-1:0] r_rx_shift, w_rx_shift_n;
   logic [CW-1:0]         r_rx_cnt, w_rx_cnt_n;
   logic                  r_rx_busy, w_rx_busy_n;
   logic [DATA_WIDTH-1:0] r_m_data, w_m_data_n;
   logic                  r_m_valid, w_m_valid_n;
   logic                  r_ovr, w_ovr_n;
   logic                  r_ferr, w_ferr_n;
   logic                  r_rxd_s1, r_rxd_s2;
   logic                  w_rxd;
   logic                  w_rx_tick;

   assign w_rxd     = r_rxd_s2;
   assign w_rx_tick = (r_rx_timer == 19'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rxd_s1   <= 1'b1;
         r_rxd_s2   <= 1'b1;
         r_rx_state <= RX_IDLE;
         r_rx_timer <= '0;
         r_rx_shift <= '0;
         r_rx_cnt   <= '0;
         r_rx_busy  <= 1'b0;
         r_m_data   <= '0;
         r_m_valid  <= 1'b0;
         r_ovr      <= 1'b0;
         r_ferr     <= 1'b0;
      end else begin
         r_rxd_s1   <= rxd;
         r_rxd_s2   <= r_rxd_s1;
         r_rx_state <= w_rx_state_n;
         r_rx_timer <= w_rx_timer_n;
         r_rx_shift <= w_rx_shift_n;
         r_rx_cnt   <= w_rx_cnt_n;
         r_rx_busy  <= w_rx_busy_n;
         r_m_data   <= w_m_data_n;
         r_m_valid  <= w_m_valid_n;
         r_ovr      <= w_ovr_n;
         r_ferr     <= w_ferr_n;
      end
   end

   always_comb begin
      w_rx_state_n = r_rx_state;
      w_rx_timer_n = w_rx_tick ? r_rx_timer : r_rx_timer - 19'd1;
      w_rx_shift_n = r_rx_shift;
      w_rx_cnt_n   = r_rx_cnt;
      w_rx_busy_n  = r_rx_busy;
      w_m_data_n   = r_m_data;
      w_m_valid_n  = r_m_valid && !m_axis_tready;
`ifdef UART_STICKY_ERR_EN
      w_ovr_n      = r_ovr;
      w_ferr_n     = r_ferr;
`else
      w_ovr_n      = 1'b0;
      w_ferr_n     = 1'b0;
`endif
      case (r_rx_state)
         RX_IDLE: begin
            w_rx_busy_n = 1'b0;
            if (!w_rxd) begin
               w_rx_state_n = RX_START;
               w_rx_busy_n  = 1'b1;
               w_rx_timer_n = w_half_load;
            end
         end
         RX_START: begin
            if (w_rx_tick) begin
               if (!w_rxd) begin
                  w_rx_state_n = RX_DATA;
                  w_rx_cnt_n   = '0;
                  w_rx_timer_n = w_bit_load;
               end else begin
                  w_rx_state_n = RX_IDLE;
                  w_rx_busy_n  = 1'b0;
               end
            end
         end
         RX_DATA: begin
            if (w_rx_tick) begin
               w_rx_shift_n = {w_rxd, r_rx_shift[DATA_WIDTH-1:1]};
               w_rx_cnt_n   = r_rx_cnt + CW'(1);
               w_rx_timer_n = w_bit_load;
               if (r_rx_cnt == CW'(DATA_WIDTH - 1))
                  w_rx_state_n = RX_STOP;
            end
         end
         RX_STOP: begin
            if (w_rx_tick) begin
               w_rx_state_n = RX_IDLE;
               w_rx_busy_n  = 1'b0;
               if (w_rxd) begin
                  w_m_data_n  = r_rx_shift;
                  w_m_valid_n = 1'b1;
                  // a byte consumed on this same edge is not an overrun
                  if (r_m_valid && !m_axis_tready)
                     w_ovr_n = 1'b1;
               end else begin
                  w_ferr_n = 1'b1;
               end
            end
         end
         default: w_rx_state_n = RX_IDLE;
      endcase
   end

   assign m_axis_tdata     = r_m_data;
   assign m_axis_tvalid    = r_m_valid;
   assign rx_busy          = r_rx_busy;
   assign rx_overrun_error = r_ovr;
   assign rx_frame_error   = r_ferr;

endmodule

// File: tb/tb_uart.sv
module tb_uart;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  s_axis_tdata = 8'h00;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        rxd;
   logic        txd;
   logic        tx_busy;
   logic        rx_busy;
   logic        rx_overrun_error;
   logic        rx_frame_error;
   logic [15:0] prescale = 16'd1;

   logic        loop_en = 1'b1;
   logic        rxd_drv = 1'b1;

   int          n_cmp = 0;
   int          n_err = 0;
   int          ovr_cnt = 0;
   int          frm_cnt = 0;
   logic [7:0]  rx_q[$];

   assign rxd = loop_en ? txd : rxd_drv;

   always #5 clk = ~clk;

   uart #(.DATA_WIDTH(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .s_axis_tdata     (s_axis_tdata),
      .s_axis_tvalid    (s_axis_tvalid),
      .s_axis_tready    (s_axis_tready),
      .m_axis_tdata     (m_axis_tdata),
      .m_axis_tvalid    (m_axis_tvalid),
      .m_axis_tready    (m_axis_tready),
      .rxd              (rxd),
      .txd              (txd),
      .tx_busy          (tx_busy),
      .rx_busy          (rx_busy),
      .rx_overrun_error (rx_overrun_error),
      .rx_frame_error   (rx_frame_error),
      .prescale         (prescale)
   );

   always @(posedge clk) begin
      if (m_axis_tvalid && m_axis_tready) rx_q.push_back(m_axis_tdata);
      if (rx_overrun_error) ovr_cnt++;
      if (rx_frame_error) frm_cnt++;
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      @(negedge clk);
      while (!s_axis_tready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (n >= 5000) begin
         n_err++;
         $display("FAIL send_timeout: tready=%b, required 1", s_axis_tready);
      end
      repeat (gap) @(negedge clk);
      s_axis_tdata  = b;
      s_axis_tvalid = 1'b1;
      @(posedge clk);
      #1 s_axis_tvalid = 1'b0;
   endtask

   task automatic wait_rx(input int cnt);
      int n;
      n = 0;
      while (rx_q.size() < cnt && n < 5000) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (rx_q.size() != cnt) begin
         n_err++;
         $display("FAIL rx_count: got %0d bytes, required %0d", rx_q.size(), cnt);
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({txd, s_axis_tready, tx_busy, m_axis_tvalid, rx_busy,
           rx_overrun_error, rx_frame_error} !== 7'b1000000) begin
         n_err++;
         $display("FAIL reset_flags: txd,rdy,txb,mv,rxb,ovr,fe=%b, required 1000000",
                  {txd, s_axis_tready, tx_busy, m_axis_tvalid, rx_busy,
                   rx_overrun_error, rx_frame_error});
      end
      n_cmp++;
      if (m_axis_tdata !== 8'h00) begin
         n_err++;
         $display("FAIL reset_tdata: got %h, required 00", m_axis_tdata);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (s_axis_tready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready_rise: got %b, required 1", s_axis_tready);
      end
   endtask

   task automatic test_loopback(input logic [7:0] pat [9], input string tag);
      loop_en = 1'b1;
      prescale = 16'd1;
      m_axis_tready = 1'b1;
      rx_q.delete();
      ovr_cnt = 0;
      frm_cnt = 0;
      for (int i = 0; i < 9; i++) send_byte(pat[i], 2);
      wait_rx(9);
      repeat (20) @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         n_cmp++;
         if (i >= rx_q.size()) begin
            n_err++;
            $display("FAIL %s byte%0d: missing, required %h", tag, i, pat[i]);
         end else if (rx_q[i] !== pat[i]) begin
            n_err++;
            $display("FAIL %s byte%0d: got %h, required %h", tag, i, rx_q[i], pat[i]);
         end
      end
      n_cmp++;
      if (ovr_cnt != 0 || frm_cnt != 0) begin
         n_err++;
         $display("FAIL %s errors: ovr=%0d fe=%0d, required 0 0", tag, ovr_cnt, frm_cnt);
      end
   endtask

   task automatic test_tx_waveform();
      logic [7:0] b;
      logic       exp_txd;
      int         bi;
      int         bad_txd, bad_busy, bad_rdy;
      b = 8'hA5;
      loop_en = 1'b0;
      rxd_drv = 1'b1;
      prescale = 16'd2;
      bad_txd = 0;
      bad_busy = 0;
      bad_rdy = 0;
      @(negedge clk);
      s_axis_tdata  = b;
      s_axis_tvalid = 1'b1;
      @(posedge clk);
      #1 s_axis_tvalid = 1'b0;
      for (int k = 0; k < 160; k++) begin
         @(negedge clk);
         bi = k / 16;
         if (bi == 0)      exp_txd = 1'b0;
         else if (bi == 9) exp_txd = 1'b1;
         else              exp_txd = b[bi-1];
         if (txd !== exp_txd) begin
            bad_txd++;
            $display("FAIL tx_wave txd@%0d: got %b, required %b", k, txd, exp_txd);
         end
         if (tx_busy !== 1'b1) bad_busy++;
         if (s_axis_tready !== 1'b0) bad_rdy++;
      end
      n_cmp++;
      if (bad_txd != 0) n_err++;
      n_cmp++;
      if (bad_busy != 0) begin
         n_err++;
         $display("FAIL tx_busy_frame: %0d cycles low, required 0", bad_busy);
      end
      n_cmp++;
      if (bad_rdy != 0) begin
         n_err++;
         $display("FAIL tx_ready_frame: %0d cycles high, required 0", bad_rdy);
      end
      @(negedge clk);
      n_cmp++;
      if ({tx_busy, s_axis_tready, txd} !== 3'b011) begin
         n_err++;
         $display("FAIL tx_frame_end: busy,rdy,txd=%b, required 011",
                  {tx_busy, s_axis_tready, txd});
      end
   endtask

   task automatic test_overrun();
      int n;
      loop_en = 1'b1;
      prescale = 16'd1;
      m_axis_tready = 1'b0;
      rx_q.delete();
      ovr_cnt = 0;
      frm_cnt = 0;
      send_byte(8'h11, 2);
      send_byte(8'h22, 2);
      n = 0;
      while (ovr_cnt == 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (m_axis_tdata !== 8'h22 || m_axis_tvalid !== 1'b1) begin
         n_err++;
         $display("FAIL overrun_data: got %h valid=%b, required 22 valid=1",
                  m_axis_tdata, m_axis_tvalid);
      end
      repeat (100) @(negedge clk);
      n_cmp++;
      if (ovr_cnt != 1 || frm_cnt != 0) begin
         n_err++;
         $display("FAIL overrun_pulses: ovr=%0d fe=%0d, required 1 0", ovr_cnt, frm_cnt);
      end
      m_axis_tready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (m_axis_tvalid !== 1'b0 || rx_q.size() != 1) begin
         n_err++;
         $display("FAIL overrun_drain: valid=%b popped=%0d, required 0 1",
                  m_axis_tvalid, rx_q.size());
      end
      rx_q.delete();
   endtask

   task automatic test_frame_error();
      logic [9:0] frame;
      frame = {1'b0, 8'h3C, 1'b0};
      loop_en = 1'b0;
      prescale = 16'd1;
      m_axis_tready = 1'b1;
      rx_q.delete();
      ovr_cnt = 0;
      frm_cnt = 0;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         rxd_drv = frame[i];
         repeat (8) @(negedge clk);
      end
      rxd_drv = 1'b1;
      repeat (40) @(negedge clk);
      n_cmp++;
      if (frm_cnt != 1 || ovr_cnt != 0) begin
         n_err++;
         $display("FAIL frame_err_pulses: fe=%0d ovr=%0d, required 1 0", frm_cnt, ovr_cnt);
      end
      n_cmp++;
      if (m_axis_tvalid !== 1'b0 || rx_q.size() != 0) begin
         n_err++;
         $display("FAIL frame_err_byte: valid=%b bytes=%0d, required 0 0",
                  m_axis_tvalid, rx_q.size());
      end
   endtask

   task automatic test_glitch();
      loop_en = 1'b0;
      prescale = 16'd4;
      rx_q.delete();
      ovr_cnt = 0;
      frm_cnt = 0;
      @(negedge clk);
      rxd_drv = 1'b0;
      repeat (2) @(negedge clk);
      rxd_drv = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (rx_busy !== 1'b1) begin
         n_err++;
         $display("FAIL glitch_busy: got %b, required 1", rx_busy);
      end
      repeat (100) @(negedge clk);
      n_cmp++;
      if (rx_q.size() != 0 || ovr_cnt != 0 || frm_cnt != 0 || rx_busy !== 1'b0) begin
         n_err++;
         $display("FAIL glitch_quiet: bytes=%0d ovr=%0d fe=%0d busy=%b, required 0 0 0 0",
                  rx_q.size(), ovr_cnt, frm_cnt, rx_busy);
      end
   endtask

   task automatic test_reset_mid_tx();
      loop_en = 1'b0;
      rxd_drv = 1'b1;
      prescale = 16'd1;
      send_byte(8'h00, 0);
      repeat (30) @(negedge clk);
      n_cmp++;
      if (tx_busy !== 1'b1 || txd !== 1'b0) begin
         n_err++;
         $display("FAIL midtx_before: busy=%b txd=%b, required 1 0", tx_busy, txd);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (txd !== 1'b1 || tx_busy !== 1'b0 || s_axis_tready !== 1'b0) begin
         n_err++;
         $display("FAIL midtx_reset: txd=%b busy=%b rdy=%b, required 1 0 0",
                  txd, tx_busy, s_axis_tready);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (s_axis_tready !== 1'b1 || txd !== 1'b1) begin
         n_err++;
         $display("FAIL midtx_recover: rdy=%b txd=%b, required 1 1", s_axis_tready, txd);
      end
   endtask

   initial begin
      logic [7:0] pat_a [9];
      logic [7:0] pat_b [9];
      pat_a = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      pat_b = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
      test_reset();
      test_loopback(pat_a, "loop_walk1");
      test_loopback(pat_b, "loop_fill");
      test_tx_waveform();
      test_overrun();
      test_frame_error();
      test_glitch();
      test_reset_mid_tx();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
